atconv_pool_engine: RTL

// Parametrised successor to the fixed 64x64 atrous-conv layer. Computes a 3x3 dilated convolution with

---
 rtl/atconv_pool_engine.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/atconv_pool_engine.sv
// 3x3 dilated convolution with replication padding, bias, optional ReLU, followed by an
// optional 2x2/stride-2 max-pool with optional round-up. One memory access per cycle.
module atconv_pool_engine #(
    parameter int IMG_LOG2 = 6,
    parameter int DIL      = 2,
    parameter int DW       = 13,
    parameter int FRAC     = 4,
    localparam int AW      = 2 * IMG_LOG2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ready,
    output logic              busy,
    input  logic [9*DW-1:0]   k_flat,
    input  logic [DW-1:0]     bias,
    input  logic              relu_en,
    input  logic              pool_en,
    input  logic              ceil_en,
    output logic [AW-1:0]     iaddr,
    input  logic [DW-1:0]     idata,
    output logic              crd,
    output logic [AW-1:0]     caddr_rd,
    input  logic [DW-1:0]     cdata_rd,
    output logic              cwr,
    output logic [AW-1:0]     caddr_wr,
    output logic [DW-1:0]     cdata_wr,
    output logic              csel
);

    localparam int ACCW = 2 * DW + 4;
    localparam int PL   = IMG_LOG2 - 1;

    localparam logic [IMG_LOG2-1:0]        LAST_PIX  = '1;
    localparam logic [PL-1:0]              LAST_CELL = '1;
    localparam logic signed [IMG_LOG2+1:0] DIL_S     = (IMG_LOG2 + 2)'(DIL);
    localparam logic signed [IMG_LOG2+1:0] COORD_MAX = (IMG_LOG2 + 2)'((1 << IMG_LOG2) - 1);
    localparam logic signed [ACCW-1:0]     SAT_HI    = ACCW'((1 << (DW - 1)) - 1);
    localparam logic signed [ACCW-1:0]     SAT_LO    = ~SAT_HI;
    localparam logic signed [DW-1:0]       MOST_NEG  = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0]              MAX_INT   = {1'b0, {(DW-1-FRAC){1'b1}}, {FRAC{1'b0}}};
    localparam logic [DW-1:0]              ONE       = DW'(1 << FRAC);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_ACC_LAST, S_WR0, S_POOL_RD, S_CMP_LAST, S_WR1
    } state_e;

    state_e                  state_q, state_d;
    logic [3:0]              step_q, step_d;
    logic [IMG_LOG2-1:0]     row_q, row_d, col_q, col_d;
    logic [PL-1:0]           pi_q, pi_d, pj_q, pj_d;
    logic signed [ACCW-1:0]  acc_q, acc_d;
    logic signed [DW-1:0]    max_q, max_d;
    logic [9*DW-1:0]         k_q;
    logic [DW-1:0]           bias_q;
    logic                    relu_q, pool_q, ceil_q;

    logic [3:0]              kidx, tap_off;
    logic signed [DW-1:0]    kern;
    logic signed [2*DW-1:0]  prod;
    logic signed [ACCW-1:0]  prod_ext, bias_ext, acc_sh;
    logic [DW-1:0]           conv_res, pool_res, floor_v;
    logic                    pix_last, cell_last;

    // Offset of a tap from the centre, clamped into the image (replication padding).
    function automatic logic [IMG_LOG2-1:0] clamp_coord(input logic [IMG_LOG2-1:0] base,
                                                        input logic [1:0] off);
        logic signed [IMG_LOG2+1:0] v;
        v = $signed({2'b00, base});
        if (off == 2'd0)      v = v - DIL_S;
        else if (off == 2'd2) v = v + DIL_S;
        if (v[IMG_LOG2+1])      clamp_coord = '0;
        else if (v > COORD_MAX) clamp_coord = '1;
        else                    clamp_coord = v[IMG_LOG2-1:0];
    endfunction

    // Tap index -> {row offset, col offset}, each 0/1/2 meaning -DIL/0/+DIL.
    function automatic logic [3:0] tap_offsets(input logic [3:0] tap);
        case (tap)
            4'd0:    tap_offsets = {2'd0, 2'd0};
            4'd1:    tap_offsets = {2'd0, 2'd1};
            4'd2:    tap_offsets = {2'd0, 2'd2};
            4'd3:    tap_offsets = {2'd1, 2'd0};
            4'd5:    tap_offsets = {2'd1, 2'd2};
            4'd6:    tap_offsets = {2'd2, 2'd0};
            4'd7:    tap_offsets = {2'd2, 2'd1};
            4'd8:    tap_offsets = {2'd2, 2'd2};
            default: tap_offsets = {2'd1, 2'd1};
        endcase
    endfunction

    // NOTE: state uses non-blocking assignments under an asynchronous reset so every
    // register updates together and an abort clears everything within the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            pi_q    <= '0;
            pj_q    <= '0;
            acc_q   <= '0;
            max_q   <= '0;
            k_q     <= '0;
            bias_q  <= '0;
            relu_q  <= 1'b0;
            pool_q  <= 1'b0;
            ceil_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            row_q   <= row_d;
            col_q   <= col_d;
            pi_q    <= pi_d;
            pj_q    <= pj_d;
            acc_q   <= acc_d;
            max_q   <= max_d;
            if (state_q == S_IDLE && ready) begin
                k_q    <= k_flat;
                bias_q <= bias;
                relu_q <= relu_en;
                pool_q <= pool_en;
                ceil_q <= ceil_en;
            end
        end
    end

    // Datapath: the tap being accumulated is the one addressed in the previous cycle.
    always_comb begin
        kidx = 4'd8;
        if (state_q == S_FETCH && step_q != 4'd0) kidx = step_q - 4'd1;
        kern     = k_q[int'(kidx) * DW +: DW];
        prod     = $signed(idata) * kern;
        prod_ext = {{(ACCW-2*DW){prod[2*DW-1]}}, prod};
        bias_ext = {{(ACCW-DW-FRAC){bias_q[DW-1]}}, bias_q, {FRAC{1'b0}}};
        acc_sh   = acc_q >>> FRAC;

        if (acc_sh > SAT_HI)      conv_res = SAT_HI[DW-1:0];
        else if (acc_sh < SAT_LO) conv_res = SAT_LO[DW-1:0];
        else                      conv_res = acc_sh[DW-1:0];
        if (relu_q && conv_res[DW-1]) conv_res = '0;

        floor_v  = {max_q[DW-1:FRAC], {FRAC{1'b0}}};
        pool_res = max_q;
        if (ceil_q && max_q[FRAC-1:0] != '0)
            pool_res = (floor_v == MAX_INT) ? MAX_INT : floor_v + ONE;

        pix_last  = (row_q == LAST_PIX) && (col_q == LAST_PIX);
        cell_last = (pi_q == LAST_CELL) && (pj_q == LAST_CELL);
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        row_d    = row_q;
        col_d    = col_q;
        pi_d     = pi_q;
        pj_d     = pj_q;
        acc_d    = acc_q;
        max_d    = max_q;
        busy     = (state_q != S_IDLE);
        iaddr    = '0;
        crd      = 1'b0;
        caddr_rd = '0;
        cwr      = 1'b0;
        caddr_wr = '0;
        cdata_wr = '0;
        csel     = 1'b0;
        tap_off  = tap_offsets(step_q);

        case (state_q)
            S_IDLE: begin
                if (ready) begin
                    state_d = S_FETCH;
                    step_d  = '0;
                    row_d   = '0;
                    col_d   = '0;
                    pi_d    = '0;
                    pj_d    = '0;
                end
            end
            S_FETCH: begin
                iaddr = {clamp_coord(row_q, tap_off[3:2]), clamp_coord(col_q, tap_off[1:0])};
                acc_d = (step_q == 4'd0) ? bias_ext : acc_q + prod_ext;
                if (step_q == 4'd8) begin
                    state_d = S_ACC_LAST;
                    step_d  = '0;
                end else begin
                    step_d = step_q + 4'd1;
                end
            end
            S_ACC_LAST: begin
                acc_d   = acc_q + prod_ext;
                state_d = S_WR0;
            end
            S_WR0: begin
                cwr      = 1'b1;
                caddr_wr = {row_q, col_q};
                cdata_wr = conv_res;
                col_d    = col_q + IMG_LOG2'(1);
                if (col_q == LAST_PIX) row_d = row_q + IMG_LOG2'(1);
                if (!pix_last)   state_d = S_FETCH;
                else if (pool_q) state_d = S_POOL_RD;
                else             state_d = S_IDLE;
            end
            S_POOL_RD: begin
                crd      = 1'b1;
                caddr_rd = {pi_q, step_q[1], pj_q, step_q[0]};
                if (step_q == 4'd0)                 max_d = MOST_NEG;
                else if ($signed(cdata_rd) > max_q) max_d = $signed(cdata_rd);
                if (step_q == 4'd3) begin
                    state_d = S_CMP_LAST;
                    step_d  = '0;
                end else begin
                    step_d = step_q + 4'd1;
                end
            end
            S_CMP_LAST: begin
                if ($signed(cdata_rd) > max_q) max_d = $signed(cdata_rd);
                state_d = S_WR1;
            end
            S_WR1: begin
                cwr      = 1'b1;
                csel     = 1'b1;
                caddr_wr = {2'b00, pi_q, pj_q};
                cdata_wr = pool_res;
                pj_d     = pj_q + PL'(1);
                if (pj_q == LAST_CELL) pi_d = pi_q + PL'(1);
                state_d  = cell_last ? S_IDLE : S_POOL_RD;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
